// File: rtl/id_stage_p_pkg.sv
// Shared decode constants and FSM state type for the ID stage.
// Optional same-cycle WB bypass is selected with ID_RF_BYPASS_EN.
package id_stage_p_pkg;

  localparam logic [3:0] OP_ALU_LO = 4'h0;
  localparam logic [3:0] OP_ALU_HI = 4'h4;
  localparam logic [3:0] OP_SHF_LO = 4'h5;
  localparam logic [3:0] OP_SHF_HI = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_BR     = 4'hC;
  localparam logic [3:0] OP_JAL    = 4'hD;
  localparam logic [3:0] OP_JR     = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 0;

  typedef enum logic [1:0] {RUN, STALL, HALT} state_e;

endpackage

// File: rtl/id_stage_p_if.sv
// IF/ID, writeback, forwarding and ID/EX signals of the decode stage.
interface id_stage_p_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [15:0]       instr_i;
  logic [DATA_W-1:0] pc_i;
  logic              instr_valid_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_dst_i;
  logic [DATA_W-1:0] wb_data_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_dst_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] ex_data_i;

  logic              stall_o;
  logic              flush_o;
  logic [DATA_W-1:0] j_pc_o;
  logic              halted_o;
  logic              ex_valid_o;
  logic [DATA_W-1:0] ex_p0_o;
  logic [DATA_W-1:0] ex_p1_o;
  logic [ADDR_W-1:0] ex_p0_addr_o;
  logic [ADDR_W-1:0] ex_p1_addr_o;
  logic [ADDR_W-1:0] ex_dst_o;
  logic              ex_we_rf_o;
  logic              ex_we_mem_o;
  logic              ex_re_mem_o;
  logic              ex_wb_sel_o;
  logic              ex_src1sel_o;
  logic              ex_hlt_o;
  logic [2:0]        ex_func_o;
  logic [3:0]        ex_shamt_o;
  logic [7:0]        ex_imm8_o;

  modport master (
    output instr_i, pc_i, instr_valid_i, wb_we_i, wb_dst_i, wb_data_i,
           mem_we_i, mem_dst_i, mem_data_i, ex_data_i,
    input  stall_o, flush_o, j_pc_o, halted_o, ex_valid_o, ex_p0_o, ex_p1_o,
           ex_p0_addr_o, ex_p1_addr_o, ex_dst_o, ex_we_rf_o, ex_we_mem_o,
           ex_re_mem_o, ex_wb_sel_o, ex_src1sel_o, ex_hlt_o, ex_func_o,
           ex_shamt_o, ex_imm8_o
  );

  modport slave (
    input  instr_i, pc_i, instr_valid_i, wb_we_i, wb_dst_i, wb_data_i,
           mem_we_i, mem_dst_i, mem_data_i, ex_data_i,
    output stall_o, flush_o, j_pc_o, halted_o, ex_valid_o, ex_p0_o, ex_p1_o,
           ex_p0_addr_o, ex_p1_addr_o, ex_dst_o, ex_we_rf_o, ex_we_mem_o,
           ex_re_mem_o, ex_wb_sel_o, ex_src1sel_o, ex_hlt_o, ex_func_o,
           ex_shamt_o, ex_imm8_o
  );
endinterface

// File: rtl/id_stage_p_rf_bypass.sv
// Two-read, one-write register file with hard-wired R0.
// ID_RF_BYPASS_EN enables write-through of a same-cycle WB write.
module rf_bypass #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata0 = regs[raddr0];
    rdata1 = regs[raddr1];
`ifdef ID_RF_BYPASS_EN
    if (we && waddr == raddr0) rdata0 = wdata;
    if (we && waddr == raddr1) rdata1 = wdata;
`endif
    // R0 reads zero even while a write to it is being presented
    if (raddr0 == '0) rdata0 = '0;
    if (raddr1 == '0) rdata1 = '0;
  end

endmodule

// File: rtl/id_stage_p.sv
// Decode stage: decode, operand forwarding, load-use stall, ID jumps, halt FSM, ID/EX register.
// Define ID_RF_BYPASS_EN for register-file write-through on same-cycle WB.
module id_stage_p #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) (
  input logic         clk,
  input logic         rst_n,
  id_stage_p_if.slave bus
);
  import id_stage_p_pkg::*;

  localparam int ADDR_W = $clog2(NUM_REGS);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] p0;
    logic [DATA_W-1:0] p1;
    logic [ADDR_W-1:0] p0_addr;
    logic [ADDR_W-1:0] p1_addr;
    logic [ADDR_W-1:0] dst;
    logic              we_rf;
    logic              we_mem;
    logic              re_mem;
    logic              wb_sel;
    logic              src1sel;
    logic              hlt;
    logic [2:0]        func;
    logic [3:0]        shamt;
    logic [7:0]        imm8;
  } idex_t;

  logic [3:0]        op;
  logic [ADDR_W-1:0] rd, rs, rt;
  logic              p0_en, p1_en, is_jal, is_jr;
  logic [ADDR_W-1:0] p0_sel, p1_sel;
  idex_t             dec, idex_d, idex_q;
  logic [DATA_W-1:0] rf_p0, rf_p1, p0_fwd, p1_fwd;
  logic              ex_fwd_ok, load_in_ex, hazard;
  logic              stall, flush, issue;
  state_e            state_q, state_d;

  assign op = bus.instr_i[OP_MSB:OP_LSB];
  assign rd = bus.instr_i[RD_LSB +: ADDR_W];
  assign rs = bus.instr_i[RS_LSB +: ADDR_W];
  assign rt = bus.instr_i[RT_LSB +: ADDR_W];

  always_comb begin
    p0_en  = 1'b0;
    p1_en  = 1'b0;
    p0_sel = rs;
    p1_sel = rt;
    is_jal = 1'b0;
    is_jr  = 1'b0;
    dec       = '0;
    dec.valid = 1'b1;
    case (op) inside
      [OP_ALU_LO:OP_ALU_HI]: begin
        p0_en = 1'b1; p1_en = 1'b1;
        dec.we_rf = 1'b1; dec.dst = rd; dec.func = op[2:0];
      end
      [OP_SHF_LO:OP_SHF_HI]: begin
        p0_en = 1'b1;
        dec.we_rf = 1'b1; dec.dst = rd; dec.func = op[2:0];
        dec.shamt = bus.instr_i[RT_LSB +: 4]; dec.src1sel = 1'b1;
      end
      OP_LW: begin
        p0_en = 1'b1;
        dec.we_rf = 1'b1; dec.dst = rd; dec.re_mem = 1'b1; dec.wb_sel = 1'b1;
      end
      OP_SW: begin
        p0_en = 1'b1; p1_en = 1'b1; p1_sel = rd; dec.we_mem = 1'b1;
      end
      OP_LHB: begin
        p0_en = 1'b1; p0_sel = rd;
        dec.we_rf = 1'b1; dec.dst = rd; dec.imm8 = bus.instr_i[7:0];
      end
      OP_LLB: begin
        dec.we_rf = 1'b1; dec.dst = rd; dec.imm8 = bus.instr_i[7:0];
      end
      OP_BR:  dec.imm8 = bus.instr_i[7:0];
      OP_JAL: begin
        dec.we_rf = 1'b1; dec.dst = ADDR_W'(NUM_REGS - 1); is_jal = 1'b1;
      end
      OP_JR: begin
        p0_en = 1'b1; is_jr = 1'b1;
      end
      OP_HLT:  dec.hlt = 1'b1;
      default: ;
    endcase
    // Unused source slots read R0 so they never forward or trigger a stall
    dec.p0_addr = p0_en ? p0_sel : '0;
    dec.p1_addr = p1_en ? p1_sel : '0;
  end

  rf_bypass #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.wb_we_i),
    .waddr (bus.wb_dst_i),
    .wdata (bus.wb_data_i),
    .raddr0(dec.p0_addr),
    .raddr1(dec.p1_addr),
    .rdata0(rf_p0),
    .rdata1(rf_p1)
  );

  // A load in EX has no data yet; it stalls instead of forwarding
  assign ex_fwd_ok  = idex_q.valid && idex_q.we_rf && !idex_q.re_mem;
  assign load_in_ex = idex_q.valid && idex_q.re_mem && (idex_q.dst != '0);

  assign p0_fwd = (dec.p0_addr == '0) ? '0 :
                  (ex_fwd_ok && idex_q.dst == dec.p0_addr) ? bus.ex_data_i :
                  (bus.mem_we_i && bus.mem_dst_i == dec.p0_addr) ? bus.mem_data_i : rf_p0;
  assign p1_fwd = (dec.p1_addr == '0) ? '0 :
                  (ex_fwd_ok && idex_q.dst == dec.p1_addr) ? bus.ex_data_i :
                  (bus.mem_we_i && bus.mem_dst_i == dec.p1_addr) ? bus.mem_data_i : rf_p1;

  assign hazard = bus.instr_valid_i && load_in_ex &&
                  ((dec.p0_addr == idex_q.dst) || (dec.p1_addr == idex_q.dst));

  always_comb begin
    idex_d    = dec;
    idex_d.p0 = is_jal ? bus.pc_i + DATA_W'(1) : p0_fwd;
    idex_d.p1 = p1_fwd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    flush   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      HALT: stall = 1'b1;
      default: begin
        if (hazard) begin
          stall   = 1'b1;
          state_d = STALL;
        end else begin
          issue   = bus.instr_valid_i;
          flush   = bus.instr_valid_i && (is_jal || is_jr);
          state_d = (bus.instr_valid_i && dec.hlt) ? HALT : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     idex_q <= '0;
    else if (issue) idex_q <= idex_d;
    else            idex_q <= '0;
  end

  assign bus.stall_o  = stall;
  assign bus.flush_o  = flush;
  assign bus.j_pc_o   = is_jr ? p0_fwd
                              : bus.pc_i + {{(DATA_W-12){bus.instr_i[11]}}, bus.instr_i[11:0]};
  assign bus.halted_o = (state_q == HALT);

  assign bus.ex_valid_o   = idex_q.valid;
  assign bus.ex_p0_o      = idex_q.p0;
  assign bus.ex_p1_o      = idex_q.p1;
  assign bus.ex_p0_addr_o = idex_q.p0_addr;
  assign bus.ex_p1_addr_o = idex_q.p1_addr;
  assign bus.ex_dst_o     = idex_q.dst;
  assign bus.ex_we_rf_o   = idex_q.we_rf;
  assign bus.ex_we_mem_o  = idex_q.we_mem;
  assign bus.ex_re_mem_o  = idex_q.re_mem;
  assign bus.ex_wb_sel_o  = idex_q.wb_sel;
  assign bus.ex_src1sel_o = idex_q.src1sel;
  assign bus.ex_hlt_o     = idex_q.hlt;
  assign bus.ex_func_o    = idex_q.func;
  assign bus.ex_shamt_o   = idex_q.shamt;
  assign bus.ex_imm8_o    = idex_q.imm8;

endmodule

// File: tb/tb_id_stage_p.sv
// Directed and randomized checks of id_stage_p against a behavioural decode/forward/hazard model.
module tb_id_stage_p;

  localparam int DW = 16;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_p_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();
  id_stage_p #(.DATA_W(DW), .NUM_REGS(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic        valid;
    logic [15:0] p0, p1;
    logic [3:0]  a0, a1, dst;
    logic        we_rf, we_mem, re_mem, wb_sel, src1sel, hlt;
    logic [2:0]  func;
    logic [3:0]  shamt;
    logic [7:0]  imm8;
  } word_t;

  typedef struct packed {
    logic  jal, jr;
    word_t w;
  } dec_t;

  word_t       m_ex;
  logic        m_halted;
  logic [15:0] m_rf [16];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        s_stall, s_flush;
  logic [15:0] s_jpc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference decode: an address of 0 means "no read"
  function automatic dec_t decode(input logic [15:0] ins);
    dec_t d;
    logic [3:0] op, rd, rs, rt;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    d = '0;
    d.w.valid = 1'b1;
    if (op < 4'd5) begin
      d.w.a0 = rs; d.w.a1 = rt; d.w.we_rf = 1'b1; d.w.dst = rd; d.w.func = op[2:0];
    end else if (op < 4'd8) begin
      d.w.a0 = rs; d.w.we_rf = 1'b1; d.w.dst = rd; d.w.func = op[2:0];
      d.w.shamt = rt; d.w.src1sel = 1'b1;
    end else if (op == 4'd8) begin
      d.w.a0 = rs; d.w.we_rf = 1'b1; d.w.dst = rd; d.w.re_mem = 1'b1; d.w.wb_sel = 1'b1;
    end else if (op == 4'd9) begin
      d.w.a0 = rs; d.w.a1 = rd; d.w.we_mem = 1'b1;
    end else if (op == 4'd10) begin
      d.w.a0 = rd; d.w.we_rf = 1'b1; d.w.dst = rd; d.w.imm8 = ins[7:0];
    end else if (op == 4'd11) begin
      d.w.we_rf = 1'b1; d.w.dst = rd; d.w.imm8 = ins[7:0];
    end else if (op == 4'd12) begin
      d.w.imm8 = ins[7:0];
    end else if (op == 4'd13) begin
      d.w.we_rf = 1'b1; d.w.dst = 4'd15; d.jal = 1'b1;
    end else if (op == 4'd14) begin
      d.w.a0 = rs; d.jr = 1'b1;
    end else begin
      d.w.hlt = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [15:0] rd_val(input logic [3:0] a);
    if (a == 4'd0) return 16'h0;
    if (m_ex.valid && m_ex.we_rf && !m_ex.re_mem && m_ex.dst == a) return bus.ex_data_i;
    if (bus.mem_we_i && bus.mem_dst_i == a) return bus.mem_data_i;
`ifdef ID_RF_BYPASS_EN
    if (bus.wb_we_i && bus.wb_dst_i == a) return bus.wb_data_i;
`endif
    return m_rf[a];
  endfunction

  task automatic set_idle();
    bus.instr_i = '0; bus.pc_i = '0; bus.instr_valid_i = 1'b0;
    bus.wb_we_i = 1'b0; bus.wb_dst_i = '0; bus.wb_data_i = '0;
    bus.mem_we_i = 1'b0; bus.mem_dst_i = '0; bus.mem_data_i = '0;
    bus.ex_data_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ex = '0;
    m_halted = 1'b0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
  endtask

  // Check one cycle at the negedge, then advance the model across the posedge
  task automatic cycle();
    dec_t d;
    word_t nxt;
    logic [15:0] v0, v1, e_jpc, wdat;
    logic [3:0] wdst;
    logic hz, e_stall, e_flush, iss, wwe;
    @(negedge clk);
    d  = decode(bus.instr_i);
    v0 = rd_val(d.w.a0);
    v1 = rd_val(d.w.a1);
    hz = bus.instr_valid_i && m_ex.valid && m_ex.re_mem && m_ex.dst != 4'd0 &&
         ((d.w.a0 == m_ex.dst) || (d.w.a1 == m_ex.dst));
    e_stall = m_halted || hz;
    e_flush = !e_stall && bus.instr_valid_i && (d.jal || d.jr);
    e_jpc   = d.jr ? v0 : bus.pc_i + {{4{bus.instr_i[11]}}, bus.instr_i[11:0]};
    s_stall = bus.stall_o; s_flush = bus.flush_o; s_jpc = bus.j_pc_o;
    chk("stall", 64'(bus.stall_o), 64'(e_stall));
    chk("flush", 64'(bus.flush_o), 64'(e_flush));
    chk("halted", 64'(bus.halted_o), 64'(m_halted));
    if (e_flush) chk("j_pc", 64'(bus.j_pc_o), 64'(e_jpc));
    chk("ex_valid", 64'(bus.ex_valid_o), 64'(m_ex.valid));
    chk("ex_p0", 64'(bus.ex_p0_o), 64'(m_ex.p0));
    chk("ex_p1", 64'(bus.ex_p1_o), 64'(m_ex.p1));
    chk("ex_ctl", 64'({bus.ex_p0_addr_o, bus.ex_p1_addr_o, bus.ex_dst_o, bus.ex_we_rf_o,
                       bus.ex_we_mem_o, bus.ex_re_mem_o, bus.ex_wb_sel_o, bus.ex_src1sel_o,
                       bus.ex_hlt_o, bus.ex_func_o, bus.ex_shamt_o, bus.ex_imm8_o}),
                  64'({m_ex.a0, m_ex.a1, m_ex.dst, m_ex.we_rf, m_ex.we_mem, m_ex.re_mem,
                       m_ex.wb_sel, m_ex.src1sel, m_ex.hlt, m_ex.func, m_ex.shamt, m_ex.imm8}));
    iss = bus.instr_valid_i && !e_stall;
    nxt = '0;
    if (iss) begin
      nxt = d.w;
      nxt.p0 = d.jal ? bus.pc_i + 16'd1 : v0;
      nxt.p1 = v1;
    end
    wwe = bus.wb_we_i; wdst = bus.wb_dst_i; wdat = bus.wb_data_i;
    @(posedge clk); #1;
    m_ex = nxt;
    if (iss && d.w.hlt) m_halted = 1'b1;
    if (wwe && wdst != 4'd0) m_rf[wdst] = wdat;
  endtask

  initial begin
    do_reset();
    cycle();
    chk("rst_ex_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("rst_halted", 64'(bus.halted_o), 64'd0);

    // WB R3=0x1234, then ADD R5,R3,R0
    bus.wb_we_i = 1'b1; bus.wb_dst_i = 4'd3; bus.wb_data_i = 16'h1234;
    cycle();
    bus.wb_we_i = 1'b0;
    bus.instr_i = 16'h0530; bus.instr_valid_i = 1'b1;
    cycle();
    chk("tp_add_p0", 64'(bus.ex_p0_o), 64'h1234);
    chk("tp_add_dst", 64'(bus.ex_dst_o), 64'd5);
    chk("tp_add_valid", 64'(bus.ex_valid_o), 64'd1);

    // LW R2 then ADD R4,R2,R1: one stall, a bubble, then MEM-forwarded issue
    bus.instr_i = 16'h8210;
    cycle();
    bus.instr_i = 16'h0421;
    cycle();
    chk("tp_lu_stall", 64'(s_stall), 64'd1);
    chk("tp_lu_noflush", 64'(s_flush), 64'd0);
    chk("tp_lu_bubble", 64'(bus.ex_valid_o), 64'd0);
    bus.mem_we_i = 1'b1; bus.mem_dst_i = 4'd2; bus.mem_data_i = 16'hBEEF;
    cycle();
    chk("tp_lu_release", 64'(s_stall), 64'd0);
    chk("tp_lu_p0", 64'(bus.ex_p0_o), 64'hBEEF);
    chk("tp_lu_dst", 64'(bus.ex_dst_o), 64'd4);
    bus.mem_we_i = 1'b0;

    // ADD R7 in EX producing 0x00AA, JR R7 in ID
    bus.instr_i = 16'h0700;
    cycle();
    bus.instr_i = 16'hE070; bus.ex_data_i = 16'h00AA;
    cycle();
    chk("tp_jr_flush", 64'(s_flush), 64'd1);
    chk("tp_jr_target", 64'(s_jpc), 64'h00AA);

    // JAL at 0x0010 with offset -2
    bus.instr_i = 16'hDFFE; bus.pc_i = 16'h0010;
    cycle();
    chk("tp_jal_target", 64'(s_jpc), 64'h000E);
    chk("tp_jal_dst", 64'(bus.ex_dst_o), 64'd15);
    chk("tp_jal_p0", 64'(bus.ex_p0_o), 64'h0011);

    // HLT freezes issue until reset
    bus.instr_i = 16'hF000;
    cycle();
    chk("tp_hlt_halted", 64'(bus.halted_o), 64'd1);
    bus.instr_i = 16'h0123;
    cycle();
    chk("tp_hlt_stall", 64'(s_stall), 64'd1);
    chk("tp_hlt_noissue", 64'(bus.ex_valid_o), 64'd0);
    do_reset();
    cycle();
    chk("tp_rst_halted", 64'(bus.halted_o), 64'd0);
    chk("tp_rst_p0", 64'(bus.ex_p0_o), 64'd0);

    // Same-cycle WB write of R9 while ADD R6,R9,R0 reads it
    bus.wb_we_i = 1'b1; bus.wb_dst_i = 4'd9; bus.wb_data_i = 16'h1111;
    cycle();
    bus.wb_data_i = 16'h5555; bus.instr_i = 16'h0690; bus.instr_valid_i = 1'b1;
    cycle();
`ifdef ID_RF_BYPASS_EN
    chk("tp_wb_bypass", 64'(bus.ex_p0_o), 64'h5555);
`else
    chk("tp_wb_bypass", 64'(bus.ex_p0_o), 64'h1111);
`endif
    bus.wb_we_i = 1'b0;

    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
      bus.instr_i = {op, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      if ($urandom_range(0, 3) == 0) bus.instr_i[11:0] = 12'($urandom);
      bus.pc_i          = 16'($urandom);
      bus.instr_valid_i = ($urandom_range(0, 9) != 0);
      bus.wb_we_i       = 1'($urandom);
      bus.wb_dst_i      = 4'($urandom_range(0, 5));
      bus.wb_data_i     = 16'($urandom);
      bus.mem_we_i      = 1'($urandom);
      bus.mem_dst_i     = 4'($urandom_range(0, 5));
      bus.mem_data_i    = 16'($urandom);
      bus.ex_data_i     = 16'($urandom);
      cycle();
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
